river_crossing_ctrl: RTL
========================

Name: river_crossing_ctrl

Overview:
Sequential successor to the combinational farmer/goat/wolf/cabbage alarm. It holds the bank position of the farmer and of N_ITEMS cargo items, and accepts one move request per handshake. Each move is checked for legality and safety against a parametrised conflict matrix. The block tracks game state (PLAY/WIN/LOST), counts accepted moves, and drives a registered alarm. It sits between the board's debounced switch/button front end and the seven-segment/LED display logic.

Parameters:
N_ITEMS, 3, number of cargo items; default item 0=cabbage, 1=goat, 2=wolf.
CONFLICT_MASK, 9'h022, N_ITEMS*N_ITEMS bits; bit i*N_ITEMS+j (i<j) set means items i and j may not share a bank without the farmer. Bits with i>=j are ignored.
STRICT_MODE, 0, 1 = unsafe moves are rejected; 0 = unsafe moves are accepted and the game is lost.
CNT_W, 6, width of move counter.
ITEM_W, $clog2(N_ITEMS+1), width of move code.

Ports:
Clock  in  1  system clock, rising edge.
Resetn  in  1  asynchronous active-low reset.
restart  in  1  synchronous restart to the start position, any state.
move_valid  in  1  move request, sampled while move_ready=1.
move_item  in  ITEM_W  0 = farmer crosses alone; k = farmer carries item k-1.
move_ready  out  1  high in PLAY, low in WIN/LOST.
move_accept  out  1  one-cycle pulse, the cycle after an accepted request.
move_reject  out  1  one-cycle pulse, the cycle after a rejected request.
reject_code  out  2  0 none, 1 item not on farmer's bank, 2 unsafe (STRICT_MODE=1 only), 3 invalid code or game over; held until the next request.
farmer_side  out  1  0 = start bank, 1 = far bank.
pos  out  N_ITEMS  bank of each item.
state  out  2  0 PLAY, 1 WIN, 2 LOST.
alarm  out  1  registered; 1 only in LOST.
win  out  1  equals (state==WIN).
move_count  out  CNT_W  accepted moves, saturating.

Behaviour:
- Reset (Resetn=0, asynchronous): state=PLAY, farmer_side=0, pos=0, alarm=0, move_count=0, move_accept=0, move_reject=0, reject_code=0.
- restart=1 at a clock edge: same values as reset, synchronously. restart has priority over a simultaneous move_valid, and that request is dropped with no pulse.
- A request is evaluated on an edge with move_valid=1. All results register on that edge, so outputs are valid the next cycle (latency 1). Back-to-back requests on consecutive cycles are legal.
- Move code checks:
  - move_valid in WIN/LOST: reject, code 3, no state change.
  - move_item > N_ITEMS: reject, code 3.
  - move_item=k>0 with pos[k-1] != farmer_side: reject, code 1.
- Otherwise compute the next position: farmer_side toggles, and for k>0 pos[k-1] toggles.
- Unsafe: some set pair (i,j) has next pos[i] == next pos[j] != next farmer_side.
  - STRICT_MODE=1 and unsafe: reject, code 2, positions and count unchanged.
  - STRICT_MODE=0 and unsafe: accept, commit positions, state→LOST, alarm=1.
- Accepted move: move_count increments, saturating at 2^CNT_W-1.
- Win: after the commit, farmer_side=1 and all pos=1 → state→WIN. Win is checked only on safe moves; an unsafe move always yields LOST.
- State transitions: PLAY→WIN, PLAY→LOST. WIN and LOST are terminal until restart or reset.
- Pulses: move_accept and move_reject are never both high. Both are 0 in any cycle after an edge without move_valid.
- Reset asserted mid-play: all state clears immediately, without waiting for Clock.

Decomposition:
- Shared package/include: state encodings (ST_PLAY, ST_WIN, ST_LOST), reject codes (REJ_NONE, REJ_SIDE, REJ_UNSAFE, REJ_INVALID), default CONFLICT_MASK.
- Sub-module river_safety_check: purely combinational, parametrised on N_ITEMS/CONFLICT_MASK. Inputs: farmer_side, pos. Output: unsafe. It is instantiated on the next-position vector. With N_ITEMS=3 and the default mask, its truth table must match the legacy four-switch alarm (input order cabbage, goat, wolf, farmer).

Test Plan:
- Reset then the classic solution 2,0,3,2,1,0,2 (STRICT_MODE=0) → seven move_accept pulses, move_count=7, pos=3'b111, farmer_side=1, state=WIN, alarm=0; a further request gets code 3.
- From start, move 0 (farmer alone), STRICT_MODE=0 → accept, state=LOST, alarm=1, move_count=1; next request is rejected with code 3.
- Same move 0 with STRICT_MODE=1 → move_reject, reject_code=2, farmer_side=0, move_count=0, state=PLAY.
- Move 2, then move 3 (wolf on bank 0, farmer on bank 1) → second request rejected, code 1, pos=3'b010, move_count=1.
- move_item=3'd4 with N_ITEMS=3 (ITEM_W=2 gives no code above 3, so use N_ITEMS=4 with mask 0 and code 5) → code 3. Drive restart and move_valid together mid-game → start position, no pulse.
- Assert Resetn low asynchronously between edges after three moves → all outputs at reset values before the next Clock edge; CNT_W=2 with 5 safe moves (mask 0) → move_count saturates at 3.

Source files
------------

// File: rtl/river_crossing_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : river_crossing_ctrl_pkg
//  Brief    : Shared encodings for the river crossing controller: game
//             states, reject codes and the default conflict matrix.
//  Revision : 1.0 - initial release
// ============================================================================
package river_crossing_ctrl_pkg;

    // Game state as presented on the state output.
    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_WIN  = 2'd1,
        ST_LOST = 2'd2
    } game_state_t;

    // Reject reasons reported on reject_code.
    localparam logic [1:0] REJ_NONE    = 2'd0;
    localparam logic [1:0] REJ_SIDE    = 2'd1;
    localparam logic [1:0] REJ_UNSAFE  = 2'd2;
    localparam logic [1:0] REJ_INVALID = 2'd3;

    // Three items: cabbage-goat (bit 0*3+1) and goat-wolf (bit 1*3+2).
    localparam logic [8:0] DEFAULT_CONFLICT_MASK = 9'h022;

endpackage
`default_nettype wire

// File: rtl/river_crossing_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : river_crossing_ctrl_if
//  Brief    : Move request handshake between the switch/button front end
//             (master) and the crossing controller (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface river_crossing_ctrl_if #(
    parameter int ITEM_W = 2
) ();

    logic              move_valid;
    logic [ITEM_W-1:0] move_item;
    logic              move_ready;
    logic              move_accept;
    logic              move_reject;
    logic [1:0]        reject_code;

    modport master (
        output move_valid,
        output move_item,
        input  move_ready,
        input  move_accept,
        input  move_reject,
        input  reject_code
    );

    modport slave (
        input  move_valid,
        input  move_item,
        output move_ready,
        output move_accept,
        output move_reject,
        output reject_code
    );

endinterface
`default_nettype wire

// File: rtl/river_crossing_ctrl_safety_check.sv
`default_nettype none
// ============================================================================
//  Module   : river_safety_check
//  Brief    : Combinational safety test of a bank configuration. Flags any
//             conflicting item pair left together on a bank without the
//             farmer. With three items and the default mask this is the old
//             four-switch alarm (cabbage, goat, wolf, farmer).
//  Revision : 1.0 - initial release
// ============================================================================
module river_safety_check
    import river_crossing_ctrl_pkg::*;
#(
    parameter int                           N_ITEMS       = 3,
    parameter logic [N_ITEMS*N_ITEMS-1:0]   CONFLICT_MASK = DEFAULT_CONFLICT_MASK
) (
    input  wire logic               farmer_side,
    input  wire logic [N_ITEMS-1:0] pos,
    output logic                    unsafe
);

    // Scan the upper triangle of the conflict matrix; lower entries are ignored.
    always_comb begin
        unsafe = 1'b0;
        for (int i = 0; i < N_ITEMS; i++) begin
            for (int j = i + 1; j < N_ITEMS; j++) begin
                if (CONFLICT_MASK[i*N_ITEMS+j] && (pos[i] == pos[j]) && (pos[i] != farmer_side)) begin
                    unsafe = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/river_crossing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : river_crossing_ctrl
//  Brief    : Sequential farmer/goat/wolf/cabbage game controller. Holds the
//             bank of the farmer and each item, validates one move per
//             request, tracks PLAY/WIN/LOST and counts accepted moves.
//  Revision : 1.0 - initial release
// ============================================================================
module river_crossing_ctrl
    import river_crossing_ctrl_pkg::*;
#(
    parameter int                           N_ITEMS       = 3,
    parameter logic [N_ITEMS*N_ITEMS-1:0]   CONFLICT_MASK = DEFAULT_CONFLICT_MASK,
    parameter bit                           STRICT_MODE   = 1'b0,
    parameter int                           CNT_W         = 6,
    parameter int                           ITEM_W        = $clog2(N_ITEMS + 1)
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 restart,
    river_crossing_ctrl_if.slave      mv,
    output logic                      farmer_side,
    output logic [N_ITEMS-1:0]        pos,
    output logic [1:0]                state,
    output logic                      alarm,
    output logic                      win,
    output logic [CNT_W-1:0]          move_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // Registered game state and its next values.
    game_state_t          r_state,   w_state_nxt;
    logic                 r_farmer,  w_farmer_nxt;
    logic [N_ITEMS-1:0]   r_pos,     w_pos_nxt;
    logic                 r_alarm,   w_alarm_nxt;
    logic [CNT_W-1:0]     r_count,   w_count_nxt;
    logic                 r_accept,  w_accept_nxt;
    logic                 r_reject,  w_reject_nxt;
    logic [1:0]           r_code,    w_code_nxt;

    // Move decode results.
    logic [N_ITEMS-1:0]   w_carry;
    logic                 w_invalid;
    logic                 w_off_side;
    logic [N_ITEMS-1:0]   w_cand_pos;
    logic                 w_cand_farmer;
    logic                 w_unsafe;

    // Decode the move code into a one-hot carry mask and the candidate banks.
    always_comb begin
        w_carry = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (int'(mv.move_item) == i + 1) begin
                w_carry[i] = 1'b1;
            end
        end
        w_invalid     = (int'(mv.move_item) > N_ITEMS);
        w_off_side    = |(w_carry & (r_pos ^ {N_ITEMS{r_farmer}}));
        w_cand_pos    = r_pos ^ w_carry;
        w_cand_farmer = ~r_farmer;
    end

    // Safety is judged on the position the move would produce.
    river_safety_check #(
        .N_ITEMS       (N_ITEMS),
        .CONFLICT_MASK (CONFLICT_MASK)
    ) u_safety (
        .farmer_side (w_cand_farmer),
        .pos         (w_cand_pos),
        .unsafe      (w_unsafe)
    );

    // Next-state and result logic; restart outranks any concurrent request.
    always_comb begin
        w_state_nxt  = r_state;
        w_farmer_nxt = r_farmer;
        w_pos_nxt    = r_pos;
        w_alarm_nxt  = r_alarm;
        w_count_nxt  = r_count;
        w_accept_nxt = 1'b0;
        w_reject_nxt = 1'b0;
        w_code_nxt   = r_code;

        if (restart) begin
            w_state_nxt  = ST_PLAY;
            w_farmer_nxt = 1'b0;
            w_pos_nxt    = '0;
            w_alarm_nxt  = 1'b0;
            w_count_nxt  = '0;
            w_code_nxt   = REJ_NONE;
        end else if (mv.move_valid) begin
            if ((r_state != ST_PLAY) || w_invalid) begin
                w_reject_nxt = 1'b1;
                w_code_nxt   = REJ_INVALID;
            end else if (w_off_side) begin
                w_reject_nxt = 1'b1;
                w_code_nxt   = REJ_SIDE;
            end else if (w_unsafe && STRICT_MODE) begin
                w_reject_nxt = 1'b1;
                w_code_nxt   = REJ_UNSAFE;
            end else begin
                w_accept_nxt = 1'b1;
                w_code_nxt   = REJ_NONE;
                w_farmer_nxt = w_cand_farmer;
                w_pos_nxt    = w_cand_pos;
                if (r_count != c_CNT_MAX) begin
                    w_count_nxt = r_count + CNT_W'(1);
                end
                // An unsafe commit always loses, even if it lands on the win position.
                if (w_unsafe) begin
                    w_state_nxt = ST_LOST;
                    w_alarm_nxt = 1'b1;
                end else if (w_cand_farmer && (&w_cand_pos)) begin
                    w_state_nxt = ST_WIN;
                end
            end
        end
    end

    // State register with asynchronous clear to the start position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_PLAY;
            r_farmer <= 1'b0;
            r_pos    <= '0;
            r_alarm  <= 1'b0;
            r_count  <= '0;
            r_accept <= 1'b0;
            r_reject <= 1'b0;
            r_code   <= REJ_NONE;
        end else begin
            r_state  <= w_state_nxt;
            r_farmer <= w_farmer_nxt;
            r_pos    <= w_pos_nxt;
            r_alarm  <= w_alarm_nxt;
            r_count  <= w_count_nxt;
            r_accept <= w_accept_nxt;
            r_reject <= w_reject_nxt;
            r_code   <= w_code_nxt;
        end
    end

    assign mv.move_ready  = (r_state == ST_PLAY);
    assign mv.move_accept = r_accept;
    assign mv.move_reject = r_reject;
    assign mv.reject_code = r_code;
    assign farmer_side    = r_farmer;
    assign pos            = r_pos;
    assign state          = r_state;
    assign alarm          = r_alarm;
    assign win            = (r_state == ST_WIN);
    assign move_count     = r_count;

endmodule
`default_nettype wire
